// File: rtl/vec_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_pkg - element-pair and bank types shared by the vector loader. rev 1.0
// ---------------------------------------------------------------------------
package vec_pkg;

  localparam int BITS_NUM = 4;
  localparam int LANES    = 4;

  typedef struct packed {
    logic [BITS_NUM-1:0] a;
    logic [BITS_NUM-1:0] b;
  } pair_t;

  typedef pair_t [LANES-1:0] bank_t;

endpackage
`default_nettype wire

// File: rtl/vec_bank_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_bank_reg - LANES x pair register bank: per-lane write, whole load. rev 1.0
// ---------------------------------------------------------------------------
module vec_bank_reg
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] wr_en,
  input  pair_t            wr_data,
  input  logic             load,
  input  bank_t            load_data,
  output bank_t            q
);

  // A whole-bank load takes priority over individual lane writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_en[i]) q[i] <= wr_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vec_stream_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_stream_loader - packs 4 streamed (a,b) beats into a double-buffered
// vector pair; optional VEC_LAST_PAD_EN adds in_last early completion. rev 1.0
// ---------------------------------------------------------------------------
module vec_stream_loader
  import vec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS_NUM-1:0] in_a,
  input  logic [BITS_NUM-1:0] in_b,
`ifdef VEC_LAST_PAD_EN
  input  logic                in_last,
`endif
  output logic [BITS_NUM-1:0] a1,
  output logic [BITS_NUM-1:0] a2,
  output logic [BITS_NUM-1:0] a3,
  output logic [BITS_NUM-1:0] a4,
  output logic [BITS_NUM-1:0] b1,
  output logic [BITS_NUM-1:0] b2,
  output logic [BITS_NUM-1:0] b3,
  output logic [BITS_NUM-1:0] b4,
  output logic                vec_valid,
  input  logic                vec_ready,
  output logic [1:0]          beat_cnt
);

  localparam logic [0:0] OB_IDLE = 1'b0;
  localparam logic [0:0] OB_FULL = 1'b1;

  logic [0:0]       ob_state;
  logic [0:0]       ob_state_nxt;
  logic             completing;
  logic             xfer;
  logic             load;
  logic [LANES-1:0] wr_en;
  pair_t            in_pair;
  bank_t            collect_q;
  bank_t            next_bank;
  bank_t            out_q;

`ifdef VEC_LAST_PAD_EN
  assign completing = (beat_cnt == 2'd3) || in_last;
`else
  assign completing = (beat_cnt == 2'd3);
`endif

  // Only a completing beat can stall; combinational path from vec_ready.
  assign in_ready = !(completing && vec_valid && !vec_ready);
  assign xfer     = in_valid && in_ready;
  assign load     = xfer && completing;
  assign in_pair  = {in_a, in_b};

  always_comb begin
    wr_en           = '0;
    wr_en[beat_cnt] = xfer;
  end

  // Output bank image: collected lanes plus the completing beat.
  always_comb begin
    next_bank           = collect_q;
    next_bank[beat_cnt] = in_pair;
`ifdef VEC_LAST_PAD_EN
    for (int i = 0; i < LANES; i++) begin
      if (2'(i) > beat_cnt) next_bank[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= 2'd0;
    end else if (xfer) begin
      beat_cnt <= completing ? 2'd0 : beat_cnt + 2'd1;
    end
  end

  vec_bank_reg u_collect (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (in_pair),
    .load      (1'b0),
    .load_data ('0),
    .q         (collect_q)
  );

  vec_bank_reg u_output (
    .clk       (clk),
    .rst       (rst),
    .wr_en     ('0),
    .wr_data   ('0),
    .load      (load),
    .load_data (next_bank),
    .q         (out_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ob_state <= OB_IDLE;
    else     ob_state <= ob_state_nxt;
  end

  always_comb begin
    ob_state_nxt = ob_state;
    case (ob_state)
      OB_IDLE: if (load) ob_state_nxt = OB_FULL;
      OB_FULL: begin
        if (load)           ob_state_nxt = OB_FULL;
        else if (vec_ready) ob_state_nxt = OB_IDLE;
      end
      default: ob_state_nxt = OB_IDLE;
    endcase
  end

  always_comb begin
    vec_valid = (ob_state == OB_FULL);
  end

  assign a1 = out_q[0].a;
  assign a2 = out_q[1].a;
  assign a3 = out_q[2].a;
  assign a4 = out_q[3].a;
  assign b1 = out_q[0].b;
  assign b2 = out_q[1].b;
  assign b3 = out_q[2].b;
  assign b4 = out_q[3].b;

endmodule
`default_nettype wire
